// File: rtl/axi_slave_mem.sv
// AXI3 slave memory responder: independent write and read FSMs over a word-addressed RAM
// with byte strobes. Protocol faults report SLVERR, but the data still moves.
module axi_slave_mem #(
  parameter int unsigned C_S_AXI_THREAD_ID_WIDTH = 6,
  parameter int unsigned C_S_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH      = 64,
  parameter int unsigned MEM_ADDR_WIDTH          = 10
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [3:0]                         S_AXI_AWLEN,
  input  logic [2:0]                         S_AXI_AWSIZE,
  input  logic [1:0]                         S_AXI_AWBURST,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WLAST,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_BID,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [3:0]                         S_AXI_ARLEN,
  input  logic [2:0]                         S_AXI_ARSIZE,
  input  logic [1:0]                         S_AXI_ARBURST,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RLAST,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY
);
  localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned B        = $clog2(NumBytes);
  localparam int unsigned Iw       = C_S_AXI_THREAD_ID_WIDTH;
  localparam int unsigned Mw       = MEM_ADDR_WIDTH;
  localparam logic [2:0]    SizeB  = 3'(B);
  localparam logic [Mw-1:0] IdxOne = Mw'(1);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

  // Holds the ready outputs low until the first edge after reset release.
  logic init_q;

  w_state_e w_state_q, w_state_d;
  logic [Iw-1:0] w_id_q;
  logic [Mw-1:0] w_idx_q;
  logic [3:0]    w_len_q, w_beat_q;
  logic [1:0]    w_burst_q, bresp_q;
  logic          w_err_q;
  logic          aw_hs, w_hs, w_last_beat, w_err_beat;

  r_state_e r_state_q, r_state_d;
  logic [Iw-1:0] rid_q;
  logic [Mw-1:0] r_idx_q, r_idx_nxt, ar_idx;
  logic [3:0]    r_len_q, r_beat_q;
  logic [1:0]    r_burst_q, rresp_q;
  logic          rlast_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic          ar_hs, r_hs;

  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = init_q && (w_state_q == WIdle);
  assign S_AXI_WREADY  = (w_state_q == WData);
  assign S_AXI_BVALID  = (w_state_q == WResp);
  assign S_AXI_BID     = w_id_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = init_q && (r_state_q == RIdle);
  assign S_AXI_RVALID  = (r_state_q == RData);
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last_beat = (w_beat_q == w_len_q);
  assign w_err_beat  = (S_AXI_WLAST != w_last_beat);
  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs        = S_AXI_RVALID && S_AXI_RREADY;
  assign ar_idx      = S_AXI_ARADDR[Mw+B-1:B];
  assign r_idx_nxt   = (r_burst_q != 2'b00) ? r_idx_q + IdxOne : r_idx_q;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && w_last_beat) w_state_d = WResp;
      WResp:   if (S_AXI_BREADY) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle: if (ar_hs) r_state_d = RData;
      RData: if (r_hs && rlast_q) r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q    <= 1'b0;
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      bresp_q   <= '0;
    end else begin
      init_q    <= 1'b1;
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_id_q    <= S_AXI_AWID;
        w_idx_q   <= S_AXI_AWADDR[Mw+B-1:B];
        w_len_q   <= S_AXI_AWLEN;
        w_beat_q  <= '0;
        w_burst_q <= S_AXI_AWBURST;
        w_err_q   <= (S_AXI_AWSIZE != SizeB);
      end
      if (w_hs) begin
        w_beat_q <= w_beat_q + 4'd1;
        w_err_q  <= w_err_q | w_err_beat;
        if (w_burst_q != 2'b00) w_idx_q <= w_idx_q + IdxOne;
        if (w_last_beat) bresp_q <= {w_err_q | w_err_beat, 1'b0};
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_idx_q][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // Read data is registered from the RAM, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rid_q     <= S_AXI_ARID;
        r_idx_q   <= ar_idx;
        r_len_q   <= S_AXI_ARLEN;
        r_beat_q  <= '0;
        r_burst_q <= S_AXI_ARBURST;
        rresp_q   <= {S_AXI_ARSIZE != SizeB, 1'b0};
        rlast_q   <= (S_AXI_ARLEN == 4'd0);
        rdata_q   <= mem[ar_idx];
      end else if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          r_idx_q  <= r_idx_nxt;
          r_beat_q <= r_beat_q + 4'd1;
          rlast_q  <= (r_beat_q + 4'd1 == r_len_q);
          rdata_q  <= mem[r_idx_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: single and burst transfers, strobes, backpressure,
// protocol errors, aliasing/wrap, same-edge read/write and reset mid-burst.
module tb_axi_slave_mem;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [5:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [3:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [63:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [7:0]  S_AXI_WSTRB;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd [16];
  logic        rl [16];
  logic [1:0]  rresp_o, bresp_o;
  logic [5:0]  rid_o, bid_o;
  int          rn;

  always #5 ACLK = ~ACLK;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at);
    int cyc;
    @(negedge ACLK);
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
    S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    cyc = 0;
    while (!S_AXI_AWREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    if (!S_AXI_AWREADY) check("aw_timeout", 0, 1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      S_AXI_WDATA = wd[b]; S_AXI_WSTRB = ws[b];
      S_AXI_WLAST = (b == last_at); S_AXI_WVALID = 1'b1;
      cyc = 0;
      while (!S_AXI_WREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
      if (!S_AXI_WREADY) check("w_timeout", 0, 1);
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    check("bvalid_latency", S_AXI_BVALID, 1);
    check("wready_after_burst", S_AXI_WREADY, 0);
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 50) begin @(negedge ACLK); cyc++; end
    bresp_o = S_AXI_BRESP; bid_o = S_AXI_BID;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("awready_after_b", S_AXI_AWREADY, 1);
  endtask

  task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bp);
    int cyc;
    bit done, stalled;
    logic [63:0] sd;
    logic sl;
    @(negedge ACLK);
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
    S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!S_AXI_ARREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    if (!S_AXI_ARREADY) check("ar_timeout", 0, 1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid_latency", S_AXI_RVALID, 1);
    done = 0; stalled = 0; cyc = 0; rn = 0; sd = '0; sl = 1'b0;
    while (!done && cyc < 200) begin
      if (stalled) begin
        check("rdata_hold", S_AXI_RDATA, sd);
        check("rlast_hold", S_AXI_RLAST, sl);
      end
      S_AXI_RREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = S_AXI_RVALID && !S_AXI_RREADY;
      sd = S_AXI_RDATA; sl = S_AXI_RLAST;
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rn < 16) begin rd[rn] = S_AXI_RDATA; rl[rn] = S_AXI_RLAST; end
        rn++;
        rresp_o = S_AXI_RRESP; rid_o = S_AXI_RID;
        if (S_AXI_RLAST) done = 1;
      end
      @(negedge ACLK);
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    if (!done) check("r_timeout", 0, 1);
    else check("arready_after_rlast", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
    S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
    S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_rlast", S_AXI_RLAST, 0);
    check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst_ids", {S_AXI_BID, S_AXI_RID}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    ARESET = 1'b0;
    #1 check("awready_before_edge", S_AXI_AWREADY, 0);
    @(negedge ACLK);
    check("awready_after_edge", S_AXI_AWREADY, 1);
    check("arready_after_edge", S_AXI_ARREADY, 1);

    // Single write then read
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(6'h2A, 32'h40, 4'd0, 3'd3, 2'b01, 0);
    check("t1_bresp", bresp_o, 2'b00);
    check("t1_bid", bid_o, 6'h2A);
    axi_read(6'h15, 32'h40, 4'd0, 3'd3, 2'b01, 0);
    check("t1_rdata", rd[0], 64'h1122334455667788);
    check("t1_rlast", rl[0], 1);
    check("t1_rresp", rresp_o, 2'b00);
    check("t1_rid", rid_o, 6'h15);
    check("t1_beats", rn, 1);

    // 16-beat INCR: prefill, then overwrite with low-half strobes on odd beats
    for (int b = 0; b < 16; b++) begin wd[b] = 64'hA5A5A5A5_00000000 + 64'(b); ws[b] = 8'hFF; end
    axi_write(6'h01, 32'h100, 4'd15, 3'd3, 2'b01, 15);
    for (int b = 0; b < 16; b++) begin wd[b] = 64'(b); ws[b] = b[0] ? 8'h0F : 8'hFF; end
    axi_write(6'h02, 32'h100, 4'd15, 3'd3, 2'b01, 15);
    check("t2_bresp", bresp_o, 2'b00);
    axi_read(6'h09, 32'h100, 4'd15, 3'd3, 2'b01, 0);
    check("t2_beats", rn, 16);
    for (int b = 0; b < 16; b++) begin
      check($sformatf("t2_data%0d", b), rd[b],
            b[0] ? {32'hA5A5A5A5, 32'(b)} : 64'(b));
      check($sformatf("t2_last%0d", b), rl[b], (b == 15) ? 1 : 0);
    end

    // Backpressure on an 8-beat read
    axi_read(6'h0C, 32'h100, 4'd7, 3'd3, 2'b10, 1);
    check("t3_beats", rn, 8);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("t3_data%0d", b), rd[b], b[0] ? {32'hA5A5A5A5, 32'(b)} : 64'(b));
    end
    check("t3_last", rl[7], 1);

    // Early WLAST: still 4 beats consumed, SLVERR, bytes written
    for (int b = 0; b < 4; b++) begin wd[b] = 64'h1000 + 64'(b); ws[b] = 8'hFF; end
    axi_write(6'h03, 32'h300, 4'd3, 3'd3, 2'b01, 1);
    check("t4_early_wlast_bresp", bresp_o, 2'b10);
    axi_read(6'h04, 32'h300, 4'd3, 3'd3, 2'b01, 0);
    check("t4_beats", rn, 4);
    check("t4_data0", rd[0], 64'h1000);
    check("t4_data3", rd[3], 64'h1003);

    // Size mismatch on write and read
    wd[0] = 64'hFEEDFACE_0BADBEEF; ws[0] = 8'hFF;
    axi_write(6'h05, 32'h380, 4'd0, 3'd2, 2'b01, 0);
    check("t4_size_bresp", bresp_o, 2'b10);
    axi_read(6'h06, 32'h380, 4'd0, 3'd2, 2'b01, 0);
    check("t4_size_rresp", rresp_o, 2'b10);
    check("t4_size_rdata", rd[0], 64'hFEEDFACE_0BADBEEF);

    // FIXED burst keeps the last beat; aliasing; index wrap at top of RAM
    wd[0] = 64'h111; wd[1] = 64'h222; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(6'h07, 32'h400, 4'd1, 3'd3, 2'b00, 1);
    axi_read(6'h07, 32'h400, 4'd0, 3'd3, 2'b01, 0);
    check("fixed_data", rd[0], 64'h222);
    axi_read(6'h08, 32'h2040, 4'd0, 3'd3, 2'b01, 0);
    check("alias_data", rd[0], 64'h1122334455667788);
    wd[0] = 64'h0BADF00D_000003FF; wd[1] = 64'h0BADF00D_00000000;
    axi_write(6'h0A, 32'h1FF8, 4'd1, 3'd3, 2'b01, 1);
    axi_read(6'h0B, 32'h0, 4'd0, 3'd3, 2'b01, 0);
    check("wrap_data", rd[0], 64'h0BADF00D_00000000);

    // Same-edge write and read of word 0x40, then reset mid-read
    @(negedge ACLK);
    S_AXI_AWID = 6'h11; S_AXI_AWADDR = 32'h40; S_AXI_AWLEN = 4'd0;
    S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
    check("t5_awready", S_AXI_AWREADY, 1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 64'hDEADBEEF_CAFEF00D; S_AXI_WSTRB = 8'hFF; S_AXI_WLAST = 1'b1;
    S_AXI_WVALID = 1'b1;
    S_AXI_ARID = 6'h12; S_AXI_ARADDR = 32'h40; S_AXI_ARLEN = 4'd3;
    S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
    check("t5_wready", S_AXI_WREADY, 1);
    check("t5_arready", S_AXI_ARREADY, 1);
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_ARVALID = 1'b0;
    check("t5_rvalid", S_AXI_RVALID, 1);
    check("t5_old_data", S_AXI_RDATA, 64'h1122334455667788);
    check("t5_bvalid", S_AXI_BVALID, 1);
    @(negedge ACLK);
    check("t5_hold_data", S_AXI_RDATA, 64'h1122334455667788);
    ARESET = 1'b1;
    #1;
    check("t5_rst_rvalid", S_AXI_RVALID, 0);
    check("t5_rst_bvalid", S_AXI_BVALID, 0);
    check("t5_rst_arready", S_AXI_ARREADY, 0);
    check("t5_rst_rdata", S_AXI_RDATA, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    #1 check("t5_arready_low", S_AXI_ARREADY, 0);
    @(negedge ACLK);
    check("t5_arready_high", S_AXI_ARREADY, 1);
    check("t5_awready_high", S_AXI_AWREADY, 1);
    axi_read(6'h13, 32'h40, 4'd0, 3'd3, 2'b01, 0);
    check("t5_new_data", rd[0], 64'hDEADBEEF_CAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
